// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and word types for the register file with
// built-in busy-bit scoreboard.
//   WIDTH_DEF    - default data word width
//   ADDR_W_DEF   - default register address width (DEPTH = 2**ADDR_W)
//   NREAD_DEF    - default number of combinational read ports
//   ZERO_REG_DEF - default index of the hardwired-zero register (DEPTH-1)
package regfile_pkg;

    localparam int WIDTH_DEF    = 64;
    localparam int ADDR_W_DEF   = 5;
    localparam int NREAD_DEF    = 2;
    localparam int ZERO_REG_DEF = (2 ** ADDR_W_DEF) - 1;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [WIDTH_DEF-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for RAW hazard detection.
//   clk_i, reset_n_i     - clock, asynchronous active-low reset
//   wr_en_i, wr_addr_i   - writeback clears the destination's busy bit
//   iss_en_i, iss_addr_i - issue reserves (sets) the destination's busy bit
//   busy_o               - registered busy vector (zero register always 0)
//   busy_count_o         - registered popcount of busy_o
//   err_reissue_o        - sticky: issue hit a register already busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = (2 ** ADDR_W) - 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic                  iss_en_i,
    input  logic [ADDR_W-1:0]     iss_addr_i,
    output logic [2**ADDR_W-1:0]  busy_o,
    output logic [ADDR_W:0]       busy_count_o,
    output logic                  err_reissue_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             err_q, err_d;
    logic             wr_clr, iss_set;

    always_comb begin
        wr_clr  = wr_en_i  && (wr_addr_i  != ZADDR);
        iss_set = iss_en_i && (iss_addr_i != ZADDR);

        // Clear first, then set: a same-cycle issue to the register being
        // written leaves it reserved for the new producer.
        busy_d = busy_q;
        if (wr_clr)  busy_d[wr_addr_i]  = 1'b0;
        if (iss_set) busy_d[iss_addr_i] = 1'b1;

        // Re-reservation is only an error when the old producer has not
        // retired in this same cycle.
        err_d = err_q;
        if (iss_set && busy_q[iss_addr_i] && !(wr_clr && (wr_addr_i == iss_addr_i)))
            err_d = 1'b1;

        // Count the next vector so busy_count tracks busy on every cycle.
        count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign busy_o        = busy_q;
    assign busy_count_o  = count_q;
    assign err_reissue_o = err_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with hardwired zero register, NREAD combinational
// read ports with writeback bypass, one synchronous write port, and a busy-bit
// scoreboard for in-flight producers.
//   clk_i, reset_n_i        - clock, asynchronous active-low reset
//   rd_addr_i / rd_data_o   - per-port read address / combinational data
//   rd_busy_o               - per-port: addressed register has pending producer
//   wr_en_i, wr_addr_i, wr_data_i - writeback
//   iss_en_i, iss_addr_i    - destination reservation at issue
//   busy_count_o            - registered number of busy registers
//   err_reissue_o           - sticky re-reservation error
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter int ZERO_REG = (2 ** ADDR_W) - 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [NREAD-1:0][ADDR_W-1:0]      rd_addr_i,
    output logic [NREAD-1:0][WIDTH-1:0]       rd_data_o,
    output logic [NREAD-1:0]                  rd_busy_o,
    input  logic                              wr_en_i,
    input  logic [ADDR_W-1:0]                 wr_addr_i,
    input  logic [WIDTH-1:0]                  wr_data_i,
    input  logic                              iss_en_i,
    input  logic [ADDR_W-1:0]                 iss_addr_i,
    output logic [ADDR_W:0]                   busy_count_o,
    output logic                              err_reissue_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0][WIDTH-1:0] regs_q;
    logic [DEPTH-1:0]            busy;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .iss_en_i      (iss_en_i),
        .iss_addr_i    (iss_addr_i),
        .busy_o        (busy),
        .busy_count_o  (busy_count_o),
        .err_reissue_o (err_reissue_o)
    );

    // The zero register's entry is never written, so it holds 0 from reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            regs_q <= '0;
        end else if (wr_en_i && (wr_addr_i != ZADDR)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Zero register beats bypass so a discarded write never leaks through.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NREAD; k++) begin
            if (rd_addr_i[k] == ZADDR) begin
                rd_data_o[k] = '0;
                rd_busy_o[k] = 1'b0;
            end else if (wr_en_i && (wr_addr_i == rd_addr_i[k])) begin
                rd_data_o[k] = wr_data_i;
                rd_busy_o[k] = 1'b0;
            end else begin
                rd_data_o[k] = regs_q[rd_addr_i[k]];
                rd_busy_o[k] = busy[rd_addr_i[k]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int WIDTH  = 64;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;
    localparam int DEPTH  = 32;
    localparam int ZR     = 31;
    localparam logic [63:0] K = 64'h0000010204080001;

    logic                          clk_i = 1'b0;
    logic                          reset_n_i;
    logic [NREAD-1:0][ADDR_W-1:0]  rd_addr_i;
    logic [NREAD-1:0][WIDTH-1:0]   rd_data_o;
    logic [NREAD-1:0]              rd_busy_o;
    logic                          wr_en_i;
    logic [ADDR_W-1:0]             wr_addr_i;
    logic [WIDTH-1:0]              wr_data_i;
    logic                          iss_en_i;
    logic [ADDR_W-1:0]             iss_addr_i;
    logic [ADDR_W:0]               busy_count_o;
    logic                          err_reissue_o;

    regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(ZR)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i),
        .busy_count_o(busy_count_o), .err_reissue_o(err_reissue_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural contents, reservation flags, sticky error.
    logic [63:0] m_mem [DEPTH];
    bit          m_busy[DEPTH];
    bit          m_err;

    typedef struct {
        bit          wr_en;
        logic [4:0]  wr_addr;
        logic [63:0] wr_data;
        bit          iss_en;
        logic [4:0]  iss_addr;
        logic [4:0]  rd0, rd1;
        logic [63:0] e_d0;
        bit          e_b0;
        logic [63:0] e_d1;
        bit          e_b1;
        int          e_cnt;
        bit          e_err;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic idle();
        wr_en_i = 0; wr_addr_i = '0; wr_data_i = '0;
        iss_en_i = 0; iss_addr_i = '0;
        rd_addr_i[0] = '0; rd_addr_i[1] = '0;
    endtask

    // One clock: model commits what the DUT sees at the edge, then we return
    // at the falling edge so the caller can drive the next cycle.
    task automatic step();
        @(posedge clk_i);
        if (reset_n_i) begin
            if (iss_en_i && iss_addr_i != ZR && m_busy[iss_addr_i] &&
                !(wr_en_i && wr_addr_i == iss_addr_i))
                m_err = 1'b1;
            if (wr_en_i && wr_addr_i != ZR) begin
                m_mem[wr_addr_i]  = wr_data_i;
                m_busy[wr_addr_i] = 1'b0;
            end
            if (iss_en_i && iss_addr_i != ZR) m_busy[iss_addr_i] = 1'b1;
        end
        @(negedge clk_i);
    endtask

    task automatic check_model(input string tag);
        logic [63:0] ed;
        bit eb;
        for (int k = 0; k < NREAD; k++) begin
            if (rd_addr_i[k] == ZR) begin
                ed = '0; eb = 0;
            end else if (wr_en_i && wr_addr_i == rd_addr_i[k]) begin
                ed = wr_data_i; eb = 0;
            end else begin
                ed = m_mem[rd_addr_i[k]]; eb = m_busy[rd_addr_i[k]];
            end
            chk($sformatf("%s rd_data[%0d]", tag, k), rd_data_o[k], ed);
            chk($sformatf("%s rd_busy[%0d]", tag, k), 64'(rd_busy_o[k]), 64'(eb));
        end
        chk({tag, " busy_count"}, 64'(busy_count_o), 64'(m_count()));
        chk({tag, " err_reissue"}, 64'(err_reissue_o), 64'(m_err));
    endtask

    initial begin
        tbl[0]  = '{1, 5, 64'hDEAD_BEEF, 0, 0, 5, 31, 64'hDEAD_BEEF, 0, 64'h0, 0, 0, 0};
        tbl[1]  = '{0, 0, 64'h0, 1, 7, 5, 5, 64'hDEAD_BEEF, 0, 64'hDEAD_BEEF, 0, 0, 0};
        tbl[2]  = '{0, 0, 64'h0, 0, 0, 7, 5, K * 7, 1, 64'hDEAD_BEEF, 0, 1, 0};
        tbl[3]  = '{1, 7, 64'h77, 0, 0, 7, 5, 64'h77, 0, 64'hDEAD_BEEF, 0, 1, 0};
        tbl[4]  = '{0, 0, 64'h0, 0, 0, 7, 5, 64'h77, 0, 64'hDEAD_BEEF, 0, 0, 0};
        tbl[5]  = '{0, 0, 64'h0, 1, 3, 3, 5, K * 3, 0, 64'hDEAD_BEEF, 0, 0, 0};
        tbl[6]  = '{0, 0, 64'h0, 1, 3, 3, 5, K * 3, 1, 64'hDEAD_BEEF, 0, 1, 0};
        tbl[7]  = '{0, 0, 64'h0, 0, 0, 3, 5, K * 3, 1, 64'hDEAD_BEEF, 0, 1, 1};
        tbl[8]  = '{1, 4, 64'h44, 1, 4, 4, 3, 64'h44, 0, K * 3, 1, 1, 1};
        tbl[9]  = '{0, 0, 64'h0, 0, 0, 4, 3, 64'h44, 1, K * 3, 1, 2, 1};
        tbl[10] = '{1, 31, 64'hA0, 0, 0, 31, 4, 64'h0, 0, 64'h44, 1, 2, 1};
        tbl[11] = '{0, 0, 64'h0, 1, 31, 31, 4, 64'h0, 0, 64'h44, 1, 2, 1};
        tbl[12] = '{0, 0, 64'h0, 0, 0, 31, 3, 64'h0, 0, K * 3, 1, 2, 1};
        tbl[13] = '{1, 3, 64'h33, 1, 4, 3, 4, 64'h33, 0, 64'h44, 1, 2, 1};
        tbl[14] = '{0, 0, 64'h0, 0, 0, 3, 4, 64'h33, 0, 64'h44, 1, 1, 1};

        // Reset and read every address on both ports.
        idle();
        reset_n_i = 1'b0;
        model_clear();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_i[0] = 5'(a);
            rd_addr_i[1] = 5'(DEPTH - 1 - a);
            #1;
            chk("reset rd_data0", rd_data_o[0], 64'h0);
            chk("reset rd_data1", rd_data_o[1], 64'h0);
            chk("reset rd_busy", 64'(rd_busy_o), 64'h0);
        end
        chk("reset busy_count", 64'(busy_count_o), 64'h0);
        chk("reset err_reissue", 64'(err_reissue_o), 64'h0);

        // Zero register discards writes; regs 0..30 hold exact values.
        idle();
        wr_en_i = 1; wr_addr_i = 5'd31; wr_data_i = 64'hA0;
        step();
        idle();
        rd_addr_i[0] = 5'd31;
        #1 chk("zero reg after write", rd_data_o[0], 64'h0);
        for (int i = 0; i < 31; i++) begin
            wr_en_i = 1; wr_addr_i = 5'(i); wr_data_i = K * 64'(i);
            step();
        end
        idle();
        for (int i = 0; i < 31; i++) begin
            rd_addr_i[0] = 5'(i);
            rd_addr_i[1] = 5'(30 - i);
            #1;
            chk($sformatf("readback p0 r%0d", i), rd_data_o[0], K * 64'(i));
            chk($sformatf("readback p1 r%0d", 30 - i), rd_data_o[1], K * 64'(30 - i));
        end

        // Directed table: bypass, issue/clear timing, reissue error, corner cases.
        for (int v = 0; v < 15; v++) begin
            wr_en_i = tbl[v].wr_en; wr_addr_i = tbl[v].wr_addr; wr_data_i = tbl[v].wr_data;
            iss_en_i = tbl[v].iss_en; iss_addr_i = tbl[v].iss_addr;
            rd_addr_i[0] = tbl[v].rd0; rd_addr_i[1] = tbl[v].rd1;
            #1;
            chk($sformatf("vec%0d rd_data0", v), rd_data_o[0], tbl[v].e_d0);
            chk($sformatf("vec%0d rd_busy0", v), 64'(rd_busy_o[0]), 64'(tbl[v].e_b0));
            chk($sformatf("vec%0d rd_data1", v), rd_data_o[1], tbl[v].e_d1);
            chk($sformatf("vec%0d rd_busy1", v), 64'(rd_busy_o[1]), 64'(tbl[v].e_b1));
            chk($sformatf("vec%0d busy_count", v), 64'(busy_count_o), 64'(tbl[v].e_cnt));
            chk($sformatf("vec%0d err_reissue", v), 64'(err_reissue_o), 64'(tbl[v].e_err));
            step();
        end

        // Randomised traffic against the reference model, from a clean reset.
        idle();
        reset_n_i = 1'b0;
        #2 reset_n_i = 1'b1;
        model_clear();
        for (int c = 0; c < 400; c++) begin
            int a;
            wr_en_i    = ($urandom_range(0, 2) != 0);
            a = $urandom_range(0, 9);
            wr_addr_i  = (a > 7) ? 5'd31 : 5'(a);
            wr_data_i  = {$urandom, $urandom};
            iss_en_i   = ($urandom_range(0, 1) != 0);
            a = $urandom_range(0, 9);
            iss_addr_i = (a > 7) ? 5'(ZR) : 5'(a);
            for (int k = 0; k < NREAD; k++) begin
                a = $urandom_range(0, 9);
                rd_addr_i[k] = (a > 7) ? 5'($urandom_range(0, 31)) : 5'(a);
            end
            #1 check_model($sformatf("rand%0d", c));
            step();
        end

        // Reserve every register, then drop reset between clock edges.
        idle();
        for (int i = 0; i < 31; i++) begin
            iss_en_i = 1; iss_addr_i = 5'(i);
            step();
        end
        idle();
        #1 chk("all issued busy_count", 64'(busy_count_o), 64'd31);
        #1 reset_n_i = 1'b0;
        #1;
        model_clear();
        chk("async reset busy_count", 64'(busy_count_o), 64'h0);
        chk("async reset err_reissue", 64'(err_reissue_o), 64'h0);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_i[0] = 5'(a);
            rd_addr_i[1] = 5'(DEPTH - 1 - a);
            #1;
            chk("async reset rd_data0", rd_data_o[0], 64'h0);
            chk("async reset rd_data1", rd_data_o[1], 64'h0);
            chk("async reset rd_busy", 64'(rd_busy_o), 64'h0);
        end
        // Issue/write while held in reset must be ignored.
        iss_en_i = 1; iss_addr_i = 5'd2; wr_en_i = 1; wr_addr_i = 5'd2; wr_data_i = 64'h55;
        step();
        idle();
        rd_addr_i[0] = 5'd2;
        #1;
        chk("held reset busy_count", 64'(busy_count_o), 64'h0);
        chk("held reset rd_data", rd_data_o[0], 64'h0);
        reset_n_i = 1'b1;
        iss_en_i = 1; iss_addr_i = 5'd9;
        step();
        idle();
        rd_addr_i[0] = 5'd9; rd_addr_i[1] = 5'd2;
        #1 check_model("post reset");
        chk("post reset rd_busy9", 64'(rd_busy_o[0]), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a built-in busy-bit scoreboard, the next generation of the single-cycle CPU's register file for the pipelined core. Provides NREAD combinational read ports with writeback bypass, one synchronous write port, a hardwired zero register, and per-register busy tracking so decode can detect RAW hazards against in-flight producers. Sits between decode (reads, issue reservations) and writeback.

## Interface
- WIDTH, 64: data width in bits.
- ADDR_W, 5: register address width; DEPTH = 2**ADDR_W registers.
- NREAD, 2: number of read ports (≥1).
- ZERO_REG, DEPTH-1: index of the hardwired-zero register.

- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NREAD×ADDR_W  read addresses.
- rd_data  out  NREAD×WIDTH  read data, combinational.
- rd_busy  out  NREAD  addressed register has a pending producer.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  WIDTH  writeback value.
- iss_en  in  1  reserve a destination (instruction issued).
- iss_addr  in  ADDR_W  destination being reserved.
- busy_count  out  ADDR_W+1  number of busy registers, registered.
- err_reissue  out  1  sticky: issue targeted an already-busy register.

## Operation
- Reset (reset_n low, asynchronous): all registers 0, all busy bits 0, busy_count 0, err_reissue 0. Holds while reset_n low; iss/wr ignored.
- Write: on posedge with wr_en=1 and wr_addr≠ZERO_REG, reg[wr_addr] ← wr_data and busy[wr_addr] ← 0. Writes to ZERO_REG discarded.
- Read port k: rd_addr=ZERO_REG → rd_data=0, rd_busy=0. Else if wr_en && wr_addr==rd_addr → rd_data=wr_data, rd_busy=0 (bypass). Else rd_data=reg[rd_addr], rd_busy=busy[rd_addr].
- Issue: on posedge with iss_en=1 and iss_addr≠ZERO_REG, busy[iss_addr] ← 1. Issue to ZERO_REG is a no-op.
- Same-cycle issue and writeback to same address: data written, busy ends 1 (new reservation wins); err_reissue not set.
- Issue to register already busy and not being written that cycle: busy stays 1, err_reissue ← 1 (sticky until reset).
- busy_count: registered popcount of the next busy vector; equals popcount(busy) every cycle. Max DEPTH-1 (zero reg never busy).

## Timing
- Read latency 0 (combinational from rd_addr, wr_*).
- Write-to-array: visible via array from cycle after posedge; visible via bypass in the write cycle itself.
- Busy set: visible on rd_busy the cycle after the issuing posedge.
- Busy clear: rd_busy drops combinationally in the writeback cycle (bypass), array bit clear from next cycle.
- busy_count and err_reissue update on the same posedge as busy bits.
- Reset asserted mid-operation: all state clears immediately, regardless of clk; first post-reset edge behaves as from idle.

## Structure
- Package regfile_pkg: default WIDTH/ADDR_W constants, ZERO_REG default, typedef for register address and data words.
- Sub-module regfile_scoreboard: busy vector, issue/clear logic, busy_count, err_reissue. Top holds data array, write decode, NREAD read muxes with bypass.

## Test plan
- Reset then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_count=0.
- Write 0xA0 to reg 31 then read 31 -> rd_data=0; write i*64'h0000010204080001 to regs 0..30, read back -> exact values.
- wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF, rd_addr[0]=5 same cycle -> rd_data[0]=64'hDEAD_BEEF, rd_busy[0]=0.
- iss reg 7 -> next cycle rd_busy=1, busy_count=1; writeback reg 7 -> rd_busy 0 in that cycle, busy_count=0 next.
- iss reg 3 twice without writeback -> err_reissue=1, busy_count=1; same-cycle iss+wr on reg 4 -> busy[4]=1, err_reissue unchanged.
- Issue regs 0..30, assert reset_n=0 between clock edges -> busy_count, all busy and data 0 immediately.
